// File: rtl/rv_mul_pkg.sv
// Shared multiply-op encodings and defaults used by the decoder, the ALU dispatcher
// and the multiplier sequencer.
package rv_mul_pkg;

    localparam int XLEN_DEF = 32;

    typedef enum logic [1:0] {
        MUL_OP_MUL    = 2'd0,
        MUL_OP_MULH   = 2'd1,
        MUL_OP_MULHSU = 2'd2,
        MUL_OP_MULHU  = 2'd3
    } mul_op_e;

    // rs1 is treated as signed for every op except MULHU
    function automatic logic a_is_signed(input mul_op_e op);
        return op != MUL_OP_MULHU;
    endfunction

    function automatic logic b_is_signed(input mul_op_e op);
        return (op == MUL_OP_MUL) || (op == MUL_OP_MULH);
    endfunction

endpackage

// File: rtl/RV_multiplier.sv
// Pipelined integer multiplier: product of the inputs enters the first stage and
// walks LATENCY register stages, all gated by enable.
module RV_multiplier #(
    parameter int WIDTHA  = 33,
    parameter int WIDTHB  = 33,
    parameter int WIDTHP  = 66,
    parameter int SIGNED  = 1,
    parameter int LATENCY = 3
) (
    input  logic              clk,
    input  logic              enable,
    input  logic [WIDTHA-1:0] a,
    input  logic [WIDTHB-1:0] b,
    output logic [WIDTHP-1:0] p
);

    logic signed [WIDTHP-1:0] a_w;
    logic signed [WIDTHP-1:0] b_w;
    logic signed [WIDTHP-1:0] prod;
    logic signed [WIDTHP-1:0] prod_p [LATENCY];

    // Extending to the product width first makes the truncated product exact.
    if (SIGNED != 0) begin : g_signed
        assign a_w = WIDTHP'($signed(a));
        assign b_w = WIDTHP'($signed(b));
    end else begin : g_unsigned
        assign a_w = WIDTHP'(a);
        assign b_w = WIDTHP'(b);
    end

    assign prod = a_w * b_w;

    // stage p0 .. p(LATENCY-1)
    always_ff @(posedge clk) begin
        if (enable) begin
            prod_p[0] <= prod;
            for (int i = 1; i < LATENCY; i++) begin
                prod_p[i] <= prod_p[i-1];
            end
        end
    end

    assign p = prod_p[LATENCY-1];

endmodule

// File: rtl/rv_mul_sequencer.sv
// Issue/writeback controller around RV_multiplier: operand extension, sideband
// (valid/op/tag) pipe aligned with the multiplier, backpressure stall and flush.
module rv_mul_sequencer
    import rv_mul_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int LATENCY = 3,
    parameter int TAGW    = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_op,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    input  logic [TAGW-1:0] in_tag,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [TAGW-1:0] out_tag,
    output logic            busy
);

    localparam int XW = XLEN + 1;
    localparam int PW = 2 * XLEN + 2;

    logic [LATENCY-1:0]     vld_p;
    mul_op_e                op_p  [LATENCY];
    logic [TAGW-1:0]        tag_p [LATENCY];
    logic                   stall;
    logic                   enable;
    logic                   accept;
    mul_op_e                op_in;
    logic signed [XW-1:0]   a_ext;
    logic signed [XW-1:0]   b_ext;
    logic signed [PW-1:0]   prod_p;
    logic                   unused_prod_hi;

    function automatic logic [XLEN-1:0] select_half(input mul_op_e op,
                                                    input logic [2*XLEN-1:0] prod);
        if (op == MUL_OP_MUL) begin
            return prod[XLEN-1:0];
        end
        return prod[2*XLEN-1:XLEN];
    endfunction

    assign op_in    = mul_op_e'(in_op);
    assign stall    = out_valid & ~out_ready;
    assign enable   = ~stall;
    assign in_ready = ~stall & ~flush;
    assign accept   = in_valid & in_ready;

    // One extra bit lets a single signed multiplier cover all four signedness mixes.
    assign a_ext = {a_is_signed(op_in) & in_a[XLEN-1], in_a};
    assign b_ext = {b_is_signed(op_in) & in_b[XLEN-1], in_b};

    RV_multiplier #(
        .WIDTHA  (XW),
        .WIDTHB  (XW),
        .WIDTHP  (PW),
        .SIGNED  (1),
        .LATENCY (LATENCY)
    ) u_mult (
        .clk    (clk),
        .enable (enable),
        .a      (a_ext),
        .b      (b_ext),
        .p      (prod_p)
    );

    // stage p0 .. p(LATENCY-1): valid bits, flush wins over stall
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_p <= '0;
        end else if (flush) begin
            vld_p <= '0;
        end else if (enable) begin
            vld_p[0] <= accept;
            for (int i = 1; i < LATENCY; i++) begin
                vld_p[i] <= vld_p[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (enable) begin
            op_p[0]  <= op_in;
            tag_p[0] <= in_tag;
            for (int i = 1; i < LATENCY; i++) begin
                op_p[i]  <= op_p[i-1];
                tag_p[i] <= tag_p[i-1];
            end
        end
    end

    assign unused_prod_hi = ^prod_p[PW-1:2*XLEN];
    assign out_valid      = vld_p[LATENCY-1];
    assign out_tag        = tag_p[LATENCY-1];
    assign out_result     = select_half(op_p[LATENCY-1], prod_p[2*XLEN-1:0]);
    assign busy           = |vld_p;

endmodule

// File: tb/tb_rv_mul_sequencer.sv
// Randomized and directed bench for rv_mul_sequencer with a queue scoreboard
// fed at acceptance and drained by an independent output monitor.
module tb_rv_mul_sequencer;

    localparam int XLEN    = 32;
    localparam int LATENCY = 3;
    localparam int TAGW    = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      in_op;
    logic [XLEN-1:0] in_a;
    logic [XLEN-1:0] in_b;
    logic [TAGW-1:0] in_tag;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_result;
    logic [TAGW-1:0] out_tag;
    logic            busy;

    typedef struct packed {
        logic [XLEN-1:0] res;
        logic [TAGW-1:0] tag;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks    = 0;
    int   errors    = 0;
    int   delivered = 0;

    logic            prev_stall = 1'b0;
    logic            prev_flush = 1'b0;
    logic [XLEN-1:0] prev_res   = '0;
    logic [TAGW-1:0] prev_tag   = '0;

    rv_mul_sequencer #(.XLEN(XLEN), .LATENCY(LATENCY), .TAGW(TAGW)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_tag     (in_tag),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Architectural result of the RISC-V M-extension multiply ops using 64-bit arithmetic.
    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        longint      sa;
        logic [63:0] p;
        sa = longint'($signed(a));
        case (op)
            2'd0: begin
                p = {32'b0, a} * {32'b0, b};
                return p[31:0];
            end
            2'd1:    p = sa * longint'($signed(b));
            2'd2:    p = sa * longint'({32'b0, b});
            default: p = {32'b0, a} * {32'b0, b};
        endcase
        return p[63:32];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard feed: every accepted request yields one expected result.
    always @(negedge clk) begin
        if (reset && in_valid && in_ready) begin
            exp_q.push_back(exp_t'{ref_mul(in_op, in_a, in_b), in_tag});
        end
    end

    // Output monitor
    always @(negedge clk) begin
        if (!reset) begin
            exp_q.delete();
            prev_stall = 1'b0;
            prev_flush = 1'b0;
        end else begin
            if (prev_stall && !prev_flush) begin
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_result", 64'(out_result), 64'(prev_res));
                chk("hold_tag", 64'(out_tag), 64'(prev_tag));
            end
            if (out_valid && !out_ready) begin
                chk("stall_in_ready", 64'(in_ready), 64'd0);
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got result %0h tag %0h, expected no output",
                             out_result, out_tag);
                end else if (out_ready) begin
                    mon_e = exp_q.pop_front();
                    chk("result", 64'(out_result), 64'(mon_e.res));
                    chk("tag", 64'(out_tag), 64'(mon_e.tag));
                    delivered++;
                end
            end
            prev_stall = out_valid & ~out_ready;
            prev_flush = flush;
            prev_res   = out_result;
            prev_tag   = out_tag;
            if (flush) begin
                exp_q.delete();
            end
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [7:0] tag);
        logic acc;
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            acc = in_ready;
            sync();
            if (acc) return;
        end
        checks++;
        errors++;
        $display("FAIL issue_timeout: got no accept, expected accept within 50 cycles");
    endtask

    task automatic wait_valid(output int k);
        k = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            k++;
            if (out_valid) return;
        end
        checks++;
        errors++;
        $display("FAIL wait_valid_timeout: got out_valid=0, expected 1 within 40 cycles");
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish before 200000");
        $fatal(1);
    end

    initial begin
        int k;
        int run;
        int d0;
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_op     = 2'd0;
        in_a      = '0;
        in_b      = '0;
        in_tag    = '0;
        flush     = 1'b0;
        out_ready = 1'b1;

        #12;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        sync();
        reset = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", 64'(in_ready), 64'd1);
        sync();

        // MUL 7 x -3, latency
        issue(2'd0, 32'h0000_0007, 32'hFFFF_FFFD, 8'h11);
        in_valid = 1'b0;
        wait_valid(k);
        chk("mul_latency", 64'(k), 64'(LATENCY));
        repeat (3) sync();

        // MULH / MULHSU / MULHU back-to-back, contiguous output
        issue(2'd1, 32'h8000_0000, 32'hFFFF_FFFF, 8'h21);
        issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 8'h22);
        issue(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 8'h23);
        in_valid = 1'b0;
        wait_valid(k);
        run = 1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (out_valid) run++;
        end
        chk("contiguous_run", 64'(run), 64'd3);
        @(negedge clk);
        chk("after_run_idle", 64'(out_valid), 64'd0);
        repeat (2) sync();

        // Four MULs with a 5-cycle output stall
        out_ready = 1'b0;
        d0 = delivered;
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    issue(2'd0, pick(), pick(), 8'(8'h40 + i));
                end
                in_valid = 1'b0;
            end
            begin
                int kk;
                wait_valid(kk);
                repeat (4) @(negedge clk);
                sync();
                out_ready = 1'b1;
            end
        join
        repeat (10) sync();
        chk("stall_delivered", 64'(delivered - d0), 64'd4);
        chk("stall_queue_empty", 64'(exp_q.size()), 64'd0);

        // Flush one cycle after two issues, with a same-cycle request
        d0 = delivered;
        issue(2'd0, pick(), pick(), 8'h51);
        issue(2'd1, pick(), pick(), 8'h52);
        in_valid = 1'b1;
        in_op    = 2'd3;
        in_tag   = 8'h53;
        flush    = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", 64'(in_ready), 64'd0);
        sync();
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("flush_busy", 64'(busy), 64'd0);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        repeat (6) sync();
        chk("flush_no_delivery", 64'(delivered - d0), 64'd0);

        // Flush while a result is held under backpressure
        out_ready = 1'b0;
        issue(2'd0, pick(), pick(), 8'h61);
        in_valid = 1'b0;
        wait_valid(k);
        repeat (2) @(negedge clk);
        sync();
        flush = 1'b1;
        sync();
        flush = 1'b0;
        @(negedge clk);
        chk("held_flush_out_valid", 64'(out_valid), 64'd0);
        chk("held_flush_in_ready", 64'(in_ready), 64'd1);
        sync();
        out_ready = 1'b1;
        repeat (2) sync();

        // Async reset between edges mid-stream
        for (int i = 0; i < 4; i++) begin
            issue(2'($urandom_range(0, 3)), pick(), pick(), 8'(8'h70 + i));
        end
        in_valid = 1'b0;
        chk("pre_reset_out_valid", 64'(out_valid), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("async_reset_out_valid", 64'(out_valid), 64'd0);
        chk("async_reset_busy", 64'(busy), 64'd0);
        repeat (2) sync();
        reset = 1'b1;
        sync();
        issue(2'd2, pick(), pick(), 8'h7F);
        in_valid = 1'b0;
        wait_valid(k);
        chk("post_reset_latency", 64'(k), 64'(LATENCY));
        repeat (3) sync();

        // Randomized traffic with backpressure and occasional flush
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_op     = 2'($urandom_range(0, 3));
            in_a      = pick();
            in_b      = pick();
            in_tag    = 8'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 49) == 0);
            sync();
        end
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (10) sync();
        chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);
        chk("drain_busy", 64'(busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rv_mul_sequencer.md
Name: rv_mul_sequencer

Overview:
- Issue/writeback controller for the team's pipelined integer multiplier (RV_multiplier), single lane.
- Accepts RISC-V M-extension multiply ops (MUL, MULH, MULHSU, MULHU) over a valid/ready handshake.
- Sign-extends the operands and tracks valid/op/tag alongside the multiplier pipe.
- Stalls the whole pipe on writeback backpressure and supports a flush that kills all in-flight ops.

Parameters:
- XLEN, 32, operand/result width.
- LATENCY, 3, multiplier pipeline depth in cycles; legal range 1..8.
- TAGW, 8, width of the opaque request tag (warp/rd id) carried through.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid & in_ready.
- in_op  in  2  0=MUL, 1=MULH, 2=MULHSU, 3=MULHU.
- in_a  in  XLEN  rs1 operand.
- in_b  in  XLEN  rs2 operand.
- in_tag  in  TAGW  request tag.
- flush  in  1  synchronous kill of all in-flight ops.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_result  out  XLEN  selected product half.
- out_tag  out  TAGW  tag of the result.
- busy  out  1  any op in flight or held at output.

Behaviour:
- Reset (reset=0, async): all stage valid bits cleared; out_valid=0, busy=0; out_result/out_tag don't-care.
- After reset, with flush=0: in_ready=1.
- stall = out_valid & ~out_ready.
- enable = ~stall drives the multiplier enable and every sideband stage register; the pipe advances only when enable=1.
- in_ready = ~stall & ~flush; in_ready is combinational and does not depend on in_valid.
- Accept: on in_valid & in_ready, stage0 captures valid=1, op, and tag. When enable=1 and nothing is accepted, stage0 captures valid=0.
- Latency: an op accepted at edge N appears with out_valid=1 after edge N+LATENCY-1, i.e. LATENCY cycles from acceptance to presentation, provided no stall. Each stall cycle adds one cycle.
- Throughput: one op per cycle; back-to-back ops stay contiguous at the output.
- Operand extension to XLEN+1 bits, with the multiplier run as SIGNED and width XLEN+1, product 2*XLEN+2:
  - MUL/MULH: both operands sign-extended.
  - MULHSU: a sign-extended, b zero-extended.
  - MULHU: both zero-extended.
- Result selection uses the op in the last stage: MUL -> product[XLEN-1:0]; all others -> product[2*XLEN-1:XLEN].
- Sideband stages (valid, op, tag) are a LATENCY-deep shift register aligned exactly with the multiplier data stages. out_valid, out_tag, and the op are taken from the last stage.
- Output hold: while stall=1, out_valid, out_result, and out_tag stay constant. All stages freeze and no new op is accepted.
- Flush: at the edge where flush=1, all stage valid bits go to 0 regardless of stall. out_valid=0 the next cycle, and a same-cycle in_valid is not accepted.
- Flush with out_valid & out_ready in the same cycle: that result counts as delivered; flush only clears state.
- busy = OR of all stage valid bits.
- Reset asserted mid-operation: all ops are dropped immediately (async); no partial output.
- Data registers need no reset; only valid bits are reset.

Decomposition:
- Shared package (rv_mul_pkg): MUL_OP_* encodings (2-bit) and the XLEN default constant, reused by the decoder and the ALU dispatcher.
- One natural sub-module: an instance of the existing RV_multiplier with WIDTHA=WIDTHB=XLEN+1, WIDTHP=2*XLEN+2, SIGNED=1, LATENCY=LATENCY, and enable tied to the sequencer's enable.
- Sideband shift register and result mux stay inline.

Test Plan:
- MUL 7 x -3 (0x00000007, 0xFFFFFFFD), tag 0x11, out_ready=1 -> out_valid exactly 3 cycles after accept; out_result=0xFFFFFFEB, out_tag=0x11.
- MULH/MULHSU/MULHU with a=0x80000000, b=0xFFFFFFFF, issued back-to-back -> three consecutive valid cycles with results 0x00000000, 0x80000000, 0x7FFFFFFF.
- Four back-to-back MULs, out_ready=0 for 5 cycles when the first appears -> in_ready=0 and output held constant during the stall; all four delivered in order with no loss or duplication after release.
- Flush one cycle after issuing two ops with in_valid also high -> the same-cycle op is not accepted; no out_valid ever appears for the flushed ops; busy=0 on the next cycle.
- Flush while a result is held stalled (out_ready=0) -> out_valid=0 the next cycle; in_ready=1.
- Async reset asserted mid-stream between clock edges -> out_valid and busy drop immediately; after release, the first new op's result is correct at LATENCY.
